// File: rtl/vq6_elem_sel_if.sv
// Sample/ranking input bundle and element-select/state output bundle for vq6_elem_sel.
interface vq6_elem_sel_if #(
    parameter int W = 8
);
    logic                in_vld;
    logic                in_rdy;
    logic [2:0]          code;
    logic [2:0]          ad0, ad1, ad2, ad3, ad4, ad5;
    logic [5:0]          sel;
    logic                sel_vld;
    logic signed [W-1:0] st0, st1, st2, st3, st4, st5;
    logic                err;

    modport master (
        output in_vld, code, ad0, ad1, ad2, ad3, ad4, ad5,
        input  in_rdy, sel, sel_vld, st0, st1, st2, st3, st4, st5, err
    );

    modport slave (
        input  in_vld, code, ad0, ad1, ad2, ad3, ad4, ad5,
        output in_rdy, sel, sel_vld, st0, st1, st2, st3, st4, st5, err
    );
endinterface

// File: rtl/vq6_elem_sel.sv
// 6-element VQ DAC element selector + mismatch-shaping state; 7-cycle latency, one sample per 8 cycles,
// in_rdy low while busy. Define VQ6_SAT_EN to saturate element states instead of wrapping.
module vq6_elem_sel #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    vq6_elem_sel_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, UPD} state_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic [2:0]          code_q, code_d;
    logic [2:0]          ad_q [6];
    logic [2:0]          ad_d [6];
    logic [5:0]          work_q, work_d;
    logic                bad_q, bad_d;
    logic [5:0]          sel_q, sel_d;
    logic                sel_vld_q, sel_vld_d;
    logic signed [W-1:0] st_q [6];
    logic signed [W-1:0] st_d [6];
    logic                err_q, err_d;

    logic [2:0]          ad_in [6];
    logic [5:0]          seen;
    logic [2:0]          ad_k;

`ifdef VQ6_SAT_EN
    localparam int WE = W + 2;
    localparam logic signed [W+1:0] ST_MAX = WE'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] ST_MIN = WE'(-(2 ** (W - 1)));
    logic signed [W+1:0] nxt;
`endif

    assign ad_in[0] = bus.ad0;
    assign ad_in[1] = bus.ad1;
    assign ad_in[2] = bus.ad2;
    assign ad_in[3] = bus.ad3;
    assign ad_in[4] = bus.ad4;
    assign ad_in[5] = bus.ad5;

    // A ranking is a permutation exactly when every address 0..5 shows up.
    always_comb begin
        seen = '0;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 6; j++) begin
                if (ad_in[r] == 3'(j)) seen[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ad_k = '0;
        for (int r = 0; r < 6; r++) begin
            if (k_q == 3'(r)) ad_k = ad_q[r];
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        code_d    = code_q;
        ad_d      = ad_q;
        work_d    = work_q;
        bad_d     = bad_q;
        sel_d     = sel_q;
        sel_vld_d = 1'b0;
        st_d      = st_q;
        err_d     = err_q;
`ifdef VQ6_SAT_EN
        nxt       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_vld) begin
                    code_d  = (bus.code > 3'd6) ? 3'd6 : bus.code;
                    ad_d    = ad_in;
                    work_d  = '0;
                    k_d     = '0;
                    bad_d   = (bus.code > 3'd6) || !(&seen);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Out-of-range addresses match no element; duplicates just re-set a bit.
                if (k_q < code_q) begin
                    for (int j = 0; j < 6; j++) begin
                        if (ad_k == 3'(j)) work_d[j] = 1'b1;
                    end
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd5) state_d = UPD;
            end
            UPD: begin
                sel_d     = work_q;
                sel_vld_d = 1'b1;
                for (int i = 0; i < 6; i++) begin
`ifdef VQ6_SAT_EN
                    nxt = {{2{st_q[i][W-1]}}, st_q[i]} + WE'(code_q)
                          - (work_q[i] ? WE'(6) : WE'(0));
                    if (nxt > ST_MAX)      st_d[i] = ST_MAX[W-1:0];
                    else if (nxt < ST_MIN) st_d[i] = ST_MIN[W-1:0];
                    else                   st_d[i] = nxt[W-1:0];
`else
                    st_d[i] = st_q[i] + W'(code_q) - (work_q[i] ? W'(6) : W'(0));
`endif
                end
                if (bad_q) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            code_q    <= '0;
            ad_q      <= '{default: '0};
            work_q    <= '0;
            bad_q     <= 1'b0;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            st_q      <= '{default: '0};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            code_q    <= code_d;
            ad_q      <= ad_d;
            work_q    <= work_d;
            bad_q     <= bad_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            st_q      <= st_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_rdy  = (state_q == IDLE);
    assign bus.sel     = sel_q;
    assign bus.sel_vld = sel_vld_q;
    assign bus.st0     = st_q[0];
    assign bus.st1     = st_q[1];
    assign bus.st2     = st_q[2];
    assign bus.st3     = st_q[3];
    assign bus.st4     = st_q[4];
    assign bus.st5     = st_q[5];
    assign bus.err     = err_q;
endmodule

// File: tb/tb_vq6_elem_sel.sv
// Randomized self-checking bench for vq6_elem_sel against a per-sample arithmetic reference.
module tb_vq6_elem_sel;
    localparam int W = 8;

    logic clk;
    logic rst;
    vq6_elem_sel_if #(.W(W)) bus ();

    vq6_elem_sel #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int st_m [6];
    int err_m;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int st_of(input int i);
        case (i)
            0: return int'(bus.st0);
            1: return int'(bus.st1);
            2: return int'(bus.st2);
            3: return int'(bus.st3);
            4: return int'(bus.st4);
            default: return int'(bus.st5);
        endcase
    endfunction

    function automatic int fix(input int v);
        int m;
`ifdef VQ6_SAT_EN
        if (v > (1 << (W - 1)) - 1) return (1 << (W - 1)) - 1;
        if (v < -(1 << (W - 1))) return -(1 << (W - 1));
        return v;
`else
        m = v & ((1 << W) - 1);
        if (m >= (1 << (W - 1))) m -= (1 << W);
        return m;
`endif
    endfunction

    task automatic drive_ad(input int a [6]);
        bus.ad0 = 3'(a[0]); bus.ad1 = 3'(a[1]); bus.ad2 = 3'(a[2]);
        bus.ad3 = 3'(a[3]); bus.ad4 = 3'(a[4]); bus.ad5 = 3'(a[5]);
    endtask

    task automatic scramble();
        bus.code = 3'($urandom_range(0, 7));
        bus.ad0 = 3'($urandom); bus.ad1 = 3'($urandom); bus.ad2 = 3'($urandom);
        bus.ad3 = 3'($urandom); bus.ad4 = 3'($urandom); bus.ad5 = 3'($urandom);
    endtask

    task automatic check_outputs(input string tag, input int sel_e);
        chk({tag, ":sel"}, int'(bus.sel), sel_e);
        for (int i = 0; i < 6; i++) chk($sformatf("%s:st%0d", tag, i), st_of(i), st_m[i]);
        chk({tag, ":err"}, int'(bus.err), err_m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) st_m[i] = 0;
        err_m = 0;
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic send(input string tag, input int c, input int a [6]);
        int cc, sel_e, mask, lat, w;
        w = 0;
        while (!bus.in_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_rdy) begin
            chk({tag, ":rdy_timeout"}, 0, 1);
            return;
        end
        bus.code = 3'(c);
        drive_ad(a);
        bus.in_vld = 1'b1;
        @(negedge clk);

        cc = (c > 6) ? 6 : c;
        sel_e = 0;
        mask = 0;
        for (int r = 0; r < 6; r++) begin
            if (a[r] <= 5) begin
                mask |= (1 << a[r]);
                if (r < cc) sel_e |= (1 << a[r]);
            end
        end
        for (int i = 0; i < 6; i++)
            st_m[i] = fix(st_m[i] + cc - (((sel_e >> i) & 1) != 0 ? 6 : 0));
        if (c > 6 || mask != 63) err_m = 1;

        // Busy period: in_vld and data toggle freely and must be ignored.
        lat = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus.sel_vld) begin
                lat = cyc;
                break;
            end
            bus.in_vld = 1'($urandom);
            scramble();
        end
        bus.in_vld = 1'b0;
        chk({tag, ":latency"}, lat, 7);
        if (lat > 0) begin
            check_outputs(tag, sel_e);
            chk({tag, ":in_rdy"}, int'(bus.in_rdy), 1);
            @(negedge clk);
            chk({tag, ":pulse"}, int'(bus.sel_vld), 0);
        end
    endtask

    task automatic rand_perm(output int p [6]);
        int j, t;
        for (int i = 0; i < 6; i++) p[i] = i;
        for (int i = 5; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a [6];
        int nv;
        rst = 1'b1;
        bus.in_vld = 1'b0;
        bus.code = '0;
        a = '{0, 0, 0, 0, 0, 0};
        drive_ad(a);
        err_m = 0;
        for (int i = 0; i < 6; i++) st_m[i] = 0;

        // Reset state and idle quiet period
        do_reset();
        #1;
        check_outputs("reset", 0);
        chk("reset:in_rdy", int'(bus.in_rdy), 1);
        chk("reset:sel_vld", int'(bus.sel_vld), 0);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sel_vld) nv++;
        end
        chk("idle:no_sel_vld", nv, 0);

        // Nominal
        a = '{5, 4, 3, 2, 1, 0};
        send("nominal", 3, a);
        chk("nominal:sel_lit", int'(bus.sel), 6'b111000);
        chk("nominal:st5_lit", int'(bus.st5), -3);
        chk("nominal:st0_lit", int'(bus.st0), 3);

        // Extremes
        rand_perm(a);
        send("code0", 0, a);
        chk("code0:st5_lit", int'(bus.st5), -3);
        rand_perm(a);
        send("code6", 6, a);
        chk("code6:sel_lit", int'(bus.sel), 6'b111111);

        // Bad ranking, then sticky error through good samples
        a = '{2, 2, 0, 1, 3, 4};
        send("badrank", 2, a);
        chk("badrank:sel_lit", int'(bus.sel), 6'b000100);
        chk("badrank:err_lit", int'(bus.err), 1);
        rand_perm(a);
        send("sticky1", 4, a);
        rand_perm(a);
        send("sticky2", 1, a);
        chk("sticky:err_lit", int'(bus.err), 1);

        // Code above 6 clamps and flags
        do_reset();
        rand_perm(a);
        send("code7", 7, a);

        // Randomized samples, some with corrupted rankings
        do_reset();
        for (int n = 0; n < 40; n++) begin
            rand_perm(a);
            if ($urandom_range(0, 3) == 0) a[$urandom_range(0, 5)] = $urandom_range(0, 7);
            send($sformatf("rand%0d", n), (n < 20) ? $urandom_range(0, 6) : $urandom_range(0, 7), a);
            if (n == 19) begin
                do_reset();
            end
        end

        // Saturation / wrap
        do_reset();
        a = '{5, 4, 3, 2, 1, 0};
        for (int n = 0; n < 26; n++) send($sformatf("sat%0d", n), 5, a);
`ifdef VQ6_SAT_EN
        chk("sat:st0_lit", int'(bus.st0), 127);
`else
        chk("sat:st0_lit", int'(bus.st0), -126);
`endif
        chk("sat:st1_lit", int'(bus.st1), -26);
        chk("sat:st5_lit", int'(bus.st5), -26);

        // Reset in the middle of a sample
        do_reset();
        a = '{0, 1, 2, 3, 4, 5};
        bus.code = 3'd4;
        drive_ad(a);
        bus.in_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) st_m[i] = 0;
        err_m = 0;
        chk("midrst:in_rdy", int'(bus.in_rdy), 1);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sel_vld) nv++;
        end
        chk("midrst:no_sel_vld", nv, 0);
        check_outputs("midrst", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vq6_elem_sel.md
# vq6_elem_sel

Element selector and mismatch-shaping state keeper for the 6-element VQ DAC path. It accepts a requested element count and the 6-entry ranked address list produced by the comparator sorting network. It scatters the top-ranked addresses into a registered 6-bit element-select word for the unit-element drivers. It also updates the per-element signed state registers that feed back into the sorter as its next inputs.

## Interface
Parameters:
- W, 8, width of each signed element state; matches the sorter data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- In_vld  in  1  Code/Ad0..Ad5 valid.
- In_rdy  out  1  block can accept a sample.
- Code  in  3  number of elements to switch on, 0..6.
- Ad0..Ad5  in  3 each  ranked element addresses; Ad0 is the highest state (first choice), Ad5 the lowest.
- Sel  out  6  element select word; bit i drives element i.
- Sel_vld  out  1  one-cycle pulse when Sel is updated.
- St0..St5  out  W each, signed  element states, fed back to the sorter.
- Err  out  1  sticky error flag.

## Operation
- FSM states:
  - IDLE: In_rdy=1. On In_vld, latch Code (clamped to 6) and Ad0..Ad5, clear the work vector, set rank counter k=0, go to SCAN.
  - SCAN: one rank per cycle. If k<Code and Ad_k≤5, set work[Ad_k]=1. Increment k. Go to UPD after k=5.
  - UPD: Sel<=work, Sel_vld<=1, and for every i update St_i <= St_i + Code − (work[i] ? 6 : 0). Go to IDLE.
- Sum of all St_i is invariant: 6·Code is added and 6·Code is subtracted per sample.
- Ranking anomalies:
  - Duplicate addresses are ORed into the work vector, so fewer than Code bits are set.
  - Addresses 6 and 7 are ignored.
- Err is set at UPD if either condition held for the latched sample: Code>6, or Ad0..Ad5 was not a permutation of 0..5.
- Err is cleared only by Rst.
- In_vld outside IDLE is ignored; In_rdy is low there.

## Timing
- Reset values: Sel=0, Sel_vld=0, St0..St5=0, Err=0, FSM=IDLE, In_rdy=1.
- Sample accepted at edge E0, the edge where In_vld&In_rdy=1.
- SCAN occupies edges E1..E6.
- Sel, St and Err update at E7, and Sel_vld is high for the single cycle after E7.
- In_rdy is high again after E7.
- Latency from accept to Sel is 7 cycles; throughput is one sample per 8 cycles.
- Sel and St_i hold their values between updates.
- Rst asserted mid-SCAN or mid-UPD immediately forces all reset values; the in-flight sample is discarded and no Sel_vld is produced.
- Inputs only need to be stable on the accept edge.

## Configuration
- VQ6_SAT_EN defined: St_i saturates to [−2^(W−1), 2^(W−1)−1].
- VQ6_SAT_EN undefined: St_i wraps in two's complement.

## Test plan
- Reset: assert Rst for 3 cycles, then release → all outputs 0, In_rdy=1; no Sel_vld for 20 idle cycles.
- Nominal: from reset, Code=3, Ad0..Ad5=5,4,3,2,1,0 →
  - Sel=6'b111000 with Sel_vld exactly 7 cycles after accept.
  - St5..St3=−3, St2..St0=+3, Err=0.
- Extremes: Code=0 → Sel=0, St unchanged, Sel_vld pulses. Then Code=6 → Sel=6'b111111, St unchanged.
- Bad ranking: Code=2, Ad0..Ad5=2,2,0,1,3,4 → Sel=6'b000100, Err=1. Err stays 1 through later good samples until Rst.
- Saturation, W=8, from reset, repeat Code=5 with Ad0..Ad5=5,4,3,2,1,0 for 26 samples →
  - St0=127 with VQ6_SAT_EN, −126 without.
  - St5..St1=−26 in both builds.
- Reset mid-op: accept a sample, assert Rst at E3 → no Sel_vld, Sel and St stay 0, In_rdy=1 after release.
